// File: rtl/lcs_frame_tx.sv
// lcs_frame_tx: requests one answer byte per word from the LCS answer stage
// and serialises each latched byte as UART 8N1; one start pulse sends WORDS bytes.
module lcs_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned WORDS        = 128,
    parameter int unsigned REQ_CYCLES   = 4,
    parameter int unsigned LATCH_DLY    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dataTx,
    output logic       req,
    output logic [6:0] wordIdx,
    output logic       tx,
    output logic       busy,
    output logic       frameDone
);

    localparam int unsigned T_MAX0 = (CLKS_PER_BIT > REQ_CYCLES) ? CLKS_PER_BIT : REQ_CYCLES;
    localparam int unsigned T_MAX  = (T_MAX0 > LATCH_DLY) ? T_MAX0 : LATCH_DLY;
    localparam int unsigned TW     = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] REQ_LAST    = TW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(LATCH_DLY - 1);
    localparam logic [TW-1:0] BIT_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]    LAST_WORD   = 7'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETTLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t        r_state, w_state;
    logic [TW-1:0] r_timer, w_timer;
    logic [3:0]    r_bitcnt, w_bitcnt;
    logic [7:0]    r_shift, w_shift;
    logic          r_req, w_req;
    logic [6:0]    r_word, w_word;
    logic          r_tx, w_tx;
    logic          r_busy, w_busy;
    logic          r_done, w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_req    <= 1'b0;
            r_word   <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_timer  <= w_timer;
            r_bitcnt <= w_bitcnt;
            r_shift  <= w_shift;
            r_req    <= w_req;
            r_word   <= w_word;
            r_tx     <= w_tx;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    // Next values are computed for every output so all ports stay registered.
    always_comb begin
        w_state  = r_state;
        w_timer  = r_timer;
        w_bitcnt = r_bitcnt;
        w_shift  = r_shift;
        w_req    = r_req;
        w_word   = r_word;
        w_tx     = r_tx;
        w_done   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_tx = 1'b1;
                if (start) begin
                    w_state = S_REQ;
                    w_word  = '0;
                    w_timer = '0;
                    w_req   = 1'b1;
                end
            end
            S_REQ: begin
                if (r_timer == REQ_LAST) begin
                    w_state = S_SETTLE;
                    w_timer = '0;
                    w_req   = 1'b0;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            S_SETTLE: begin
                if (r_timer == SETTLE_LAST) begin
                    w_state = S_LOAD;
                    w_timer = '0;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            S_LOAD: begin
                w_shift  = dataTx;
                w_bitcnt = '0;
                w_timer  = '0;
                w_tx     = 1'b0;
                w_state  = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_timer == BIT_LAST) begin
                    w_timer = '0;
                    if (r_bitcnt == 4'd9) begin
                        w_state = S_GAP;
                        w_done  = (r_word == LAST_WORD);
                    end else begin
                        // bitcnt 0..7 ends start/data bits: next is a data bit; 8 ends data[7]: stop bit.
                        w_bitcnt = r_bitcnt + 4'd1;
                        if (r_bitcnt < 4'd8) begin
                            w_tx    = r_shift[0];
                            w_shift = {1'b0, r_shift[7:1]};
                        end else begin
                            w_tx = 1'b1;
                        end
                    end
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            S_GAP: begin
                if (r_word == LAST_WORD) begin
                    w_word  = '0;
                    w_state = S_IDLE;
                end else begin
                    w_word  = r_word + 7'd1;
                    w_state = S_REQ;
                    w_timer = '0;
                    w_req   = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_req   = 1'b0;
                w_tx    = 1'b1;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign req       = r_req;
    assign wordIdx   = r_word;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign frameDone = r_done;

endmodule

// File: tb/tb_lcs_frame_tx.sv
// Bench for lcs_frame_tx: a WORDS=1 instance checked against a timing table,
// and a WORDS=4 instance whose UART output is decoded against an expected-byte queue.
module tb_lcs_frame_tx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, start1;
    logic [7:0] d1;
    logic       req1, tx1, busy1, done1;
    logic [6:0] widx1;

    logic       rst4, start4;
    logic [7:0] d4;
    logic       req4, tx4, busy4, done4;
    logic [6:0] widx4;

    lcs_frame_tx #(.CLKS_PER_BIT(CPB), .WORDS(1), .REQ_CYCLES(4), .LATCH_DLY(3)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .dataTx(d1),
        .req(req1), .wordIdx(widx1), .tx(tx1), .busy(busy1), .frameDone(done1)
    );

    lcs_frame_tx #(.CLKS_PER_BIT(CPB), .WORDS(4), .REQ_CYCLES(4), .LATCH_DLY(3)) u_dut4 (
        .clk(clk), .rst(rst4), .start(start4), .dataTx(d4),
        .req(req4), .wordIdx(widx4), .tx(tx4), .busy(busy4), .frameDone(done4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting, got no event expected one", nm);
    endtask

    // Scoreboard: expected bytes queued at stimulus time, popped by the UART decoder.
    logic [7:0] exp_q[$];
    logic       mon_act = 1'b0;
    int         mon_cnt = 0;
    int         mon_b;
    logic [7:0] mon_byte;

    always @(negedge clk) begin
        if (rst4) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx4 == 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt = mon_cnt + 1;
            if (mon_cnt % CPB == CPB / 2) begin
                mon_b = mon_cnt / CPB;
                if (mon_b == 0) begin
                    chk("rx start bit", {31'd0, tx4}, 32'd0);
                end else if (mon_b <= 8) begin
                    mon_byte[mon_b-1] = tx4;
                end else begin
                    chk("rx stop bit", {31'd0, tx4}, 32'd1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx byte: got %0h expected none", mon_byte);
                    end else begin
                        chk("rx byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    int   req_rises4 = 0;
    logic req4_prev  = 1'b0;
    always @(negedge clk) begin
        if (req4 && !req4_prev) req_rises4++;
        req4_prev = req4;
    end

    task automatic wait_req4(input string nm);
        logic prev;
        int   n;
        prev = req4;
        n    = 0;
        forever begin
            @(negedge clk);
            n++;
            if (req4 && !prev) return;
            prev = req4;
            if (n > 400) begin
                timeout(nm);
                return;
            end
        end
    endtask

    task automatic wait_done4(input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (done4) return;
            if (n > 1000) begin
                timeout(nm);
                return;
            end
        end
    endtask

    typedef struct {
        int   cyc;
        int   sel;
        logic exp;
    } vec_t;

    vec_t vt[$];
    logic tr [4][200];
    int   snap, cnt_req, cnt_done;

    function automatic string sel_nm(input int s);
        case (s)
            0:       return "req";
            1:       return "tx";
            2:       return "frameDone";
            default: return "busy";
        endcase
    endfunction

    initial begin
        // Timing table for WORDS=1, dataTx=A5; cycle 0 is the first cycle req is high.
        for (int c = 0; c < 4; c++) vt.push_back('{c, 0, 1'b1});
        vt.push_back('{4, 0, 1'b0});
        vt.push_back('{7, 1, 1'b1});
        vt.push_back('{16, 1, 1'b0});
        vt.push_back('{32, 1, 1'b1});
        vt.push_back('{48, 1, 1'b0});
        vt.push_back('{64, 1, 1'b1});
        vt.push_back('{80, 1, 1'b0});
        vt.push_back('{96, 1, 1'b0});
        vt.push_back('{112, 1, 1'b1});
        vt.push_back('{128, 1, 1'b0});
        vt.push_back('{144, 1, 1'b1});
        vt.push_back('{160, 1, 1'b1});
        vt.push_back('{167, 2, 1'b0});
        vt.push_back('{168, 2, 1'b1});
        vt.push_back('{169, 2, 1'b0});
        vt.push_back('{168, 3, 1'b1});
        vt.push_back('{169, 3, 1'b0});

        rst1 = 1'b1; rst4 = 1'b1;
        start1 = 1'b0; start4 = 1'b0;
        d1 = 8'hA5; d4 = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset dut1 outputs", {26'd0, tx1, req1, busy1, done1, widx1 != 7'd0}, {26'd0, 5'b10000});
        chk("reset dut4 outputs", {26'd0, tx4, req4, busy4, done4, widx4 != 7'd0}, {26'd0, 5'b10000});
        rst1 = 1'b0; rst4 = 1'b0;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle dut1", {21'd0, tx1, req1, busy1, done1, widx1}, {21'd0, 4'b1000, 7'd0});
            chk("idle dut4", {21'd0, tx4, req4, busy4, done4, widx4}, {21'd0, 4'b1000, 7'd0});
        end

        // WORDS=1 single byte A5: capture a trace and check it against the table.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            tr[0][k] = req1;
            tr[1][k] = tx1;
            tr[2][k] = done1;
            tr[3][k] = busy1;
        end
        foreach (vt[i])
            chk($sformatf("dut1 %s at cycle %0d", sel_nm(vt[i].sel), vt[i].cyc),
                {31'd0, tr[vt[i].sel][vt[i].cyc]}, {31'd0, vt[i].exp});
        cnt_req = 0;
        cnt_done = 0;
        for (int k = 0; k < 200; k++) begin
            if (tr[0][k]) cnt_req++;
            if (tr[2][k]) cnt_done++;
        end
        chk("dut1 req high cycles", cnt_req, 4);
        chk("dut1 frameDone pulses", cnt_done, 1);
        chk("dut1 wordIdx after frame", {25'd0, widx1}, 32'd0);

        // WORDS=4, dataTx tracks 10+wordIdx.
        snap = req_rises4;
        d4 = 8'h10;
        for (int w = 0; w < 4; w++) exp_q.push_back(8'(8'h10 + w));
        start4 = 1'b1;
        for (int w = 0; w < 4; w++) begin
            wait_req4("inc req rise");
            start4 = 1'b0;
            chk("inc wordIdx", {25'd0, widx4}, w);
            d4 = 8'(8'h10 + w);
        end
        wait_done4("inc frameDone");
        chk("inc req pulses", req_rises4 - snap, 4);
        @(negedge clk);
        chk("inc wordIdx back to 0", {25'd0, widx4}, 32'd0);
        chk("inc busy low", {31'd0, busy4}, 32'd0);
        repeat (5) @(negedge clk);

        // dataTx changes while word 0 is shifting.
        d4 = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int w = 1; w < 4; w++) exp_q.push_back(8'hFF);
        start4 = 1'b1;
        wait_req4("chg req rise");
        start4 = 1'b0;
        repeat (30) @(negedge clk);
        d4 = 8'hFF;
        wait_done4("chg frameDone");
        repeat (5) @(negedge clk);

        // Reset in the middle of data bit 2 of word 2.
        d4 = 8'h3C;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        start4 = 1'b1;
        for (int w = 0; w < 3; w++) begin
            wait_req4("rst req rise");
            start4 = 1'b0;
        end
        chk("rst word index before abort", {25'd0, widx4}, 32'd2);
        repeat (60) @(negedge clk);
        rst4 = 1'b1;
        #1;
        chk("rst immediate outputs", {29'd0, tx4, req4, busy4}, {29'd0, 3'b100});
        chk("rst immediate wordIdx", {25'd0, widx4}, 32'd0);
        chk("rst bytes before abort delivered", exp_q.size(), 0);
        @(negedge clk);
        #1;
        rst4 = 1'b0;
        d4 = 8'h5A;
        for (int w = 0; w < 4; w++) exp_q.push_back(8'h5A);
        @(negedge clk);
        start4 = 1'b1;
        wait_req4("restart req rise");
        start4 = 1'b0;
        chk("restart wordIdx", {25'd0, widx4}, 32'd0);
        wait_done4("restart frameDone");
        repeat (5) @(negedge clk);

        // Start pulse while busy is ignored; start held across frame end chains a frame.
        d4 = 8'h77;
        for (int w = 0; w < 8; w++) exp_q.push_back(8'h77);
        snap = req_rises4;
        start4 = 1'b1;
        wait_req4("busy req rise");
        start4 = 1'b0;
        repeat (100) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("busy pulse wordIdx", {25'd0, widx4}, 32'd0);
        for (int w = 1; w < 4; w++) begin
            wait_req4("busy req rise");
            chk("busy wordIdx", {25'd0, widx4}, w);
        end
        start4 = 1'b1;
        wait_done4("held frameDone 1");
        chk("held req pulses frame 1", req_rises4 - snap, 4);
        @(negedge clk);
        chk("held idle gap req/busy", {30'd0, req4, busy4}, 32'd0);
        @(negedge clk);
        chk("held relaunch req/busy", {30'd0, req4, busy4}, {30'd0, 2'b11});
        chk("held relaunch wordIdx", {25'd0, widx4}, 32'd0);
        start4 = 1'b0;
        wait_done4("held frameDone 2");
        chk("held req pulses frame 2", req_rises4 - snap, 8);

        repeat (200) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcs_frame_tx.md
Name: lcs_frame_tx

Overview:
- Downstream consumer of the LCS answer stage. Paces one request per word: raises `req`, waits for the answer stage's `dataTx` to settle, latches the byte, then serialises it as UART 8N1 on `tx`.
- One `start` pulse sends a frame of WORDS bytes.
- Frame progress is exported on `wordIdx` for address generation upstream.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Legal range is 4 or more.
- WORDS, 128: bytes per frame. Legal range is 1 to 128.
- REQ_CYCLES, 4: cycles `req` is held high per word. Legal range is 3 or more, so it survives the 2-flop synchroniser in the answer stage.
- LATCH_DLY, 3: cycles after `req` falls before `dataTx` is latched. Legal range is 1 or more.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous reset, active-high.
- start, input, 1: frame start strobe. Sampled only in IDLE.
- dataTx, input, 8: answer byte from the LCS answer stage.
- req, output, 1: word request to the answer stage. Registered.
- wordIdx, output, 7: index of the word currently being requested or sent.
- tx, output, 1: UART serial line. Idles high.
- busy, output, 1: high whenever state is not IDLE.
- frameDone, output, 1: 1-cycle pulse after the last stop bit of a frame.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; req=0, wordIdx=0, tx=1, busy=0, frameDone=0.
  - Shift register, bit counter and timer all clear.
  - Reset mid-frame aborts immediately. `tx` returns high with no partial stop bit.
- All outputs are registered. `frameDone` is low except for its pulse.
- States: IDLE, REQ, SETTLE, LOAD, SHIFT, GAP.
- IDLE:
  - `start`=1 → REQ, wordIdx=0, timer=0. `req` rises on the next edge.
  - `start` while busy is ignored.
- REQ: `req`=1 for exactly REQ_CYCLES cycles, then `req`=0 → SETTLE.
- SETTLE: wait LATCH_DLY cycles → LOAD.
- LOAD (1 cycle):
  - Latch `dataTx` into the shift register.
  - Bit counter=0. `tx` goes to 0 (start bit) on the exit edge → SHIFT.
- SHIFT, per frame of 10 bits:
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Order: start bit (0), data[0]..data[7] LSB first, stop bit (1).
  - After the stop bit's last cycle → GAP.
- GAP (1 cycle):
  - wordIdx==WORDS-1: wordIdx→0, frameDone=1 for this cycle → IDLE.
  - Otherwise: wordIdx+1 → REQ.
- Req spacing: `req` is low for at least LATCH_DLY+1+10·CLKS_PER_BIT cycles between words. This guarantees the answer stage returns to its idle state and counts exactly one request per word.
- Timer is wide enough for max(CLKS_PER_BIT, REQ_CYCLES, LATCH_DLY). wordIdx wraps WORDS-1→0 only at frame end, never mid-frame.
- `dataTx` changes after LOAD do not affect the byte in flight.
- `start` high continuously: frames run back to back with one IDLE cycle between them.
- Per-word latency: REQ_CYCLES+LATCH_DLY+1+10·CLKS_PER_BIT+1 cycles. Defaults: 4+3+1+160+1 = 169.

Test Plan:
- Reset, then idle 50 cycles → tx=1, req=0, busy=0, wordIdx=0 throughout.
- WORDS=1, dataTx=8'hA5, pulse `start`:
  - req high for exactly 4 cycles.
  - tx sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1.
  - frameDone pulses once, 169 cycles after req rises.
- WORDS=4, dataTx driven as 8'h10+wordIdx → decoded bytes are 10,11,12,13. Exactly 4 req pulses. wordIdx returns to 0.
- Change dataTx during SHIFT (A5→FF) → transmitted byte remains A5. The next word latches FF.
- Assert rst for 1 cycle mid-data-bit of word 2 → tx=1, req=0, busy=0 immediately. A new `start` restarts at wordIdx=0.
- Pulse `start` while busy, and hold `start` high across a frame end → the mid-frame pulse is ignored. The held start launches a second frame one cycle after frameDone.
